// File: rtl/noc_pkt_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkt_rr_arb
// Description : Output-port packet arbiter for the NoC router. A round-robin
//               pointer plus per-port masks choose one input port. The grant
//               stays locked for a whole packet. A packet is either PKT_LEN
//               valid flits long, or it ends on a tail flit. The grant
//               drives the crossbar select.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_pkt_rr_arb #(
  parameter int N_PORTS   = 5,
  parameter int PKT_LEN   = 5,
  parameter int TAIL_MODE = 0,
  parameter int IDX_W     = $clog2(N_PORTS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] mask,
  input  logic               flit_valid,
  input  logic               flit_tail,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [N_PORTS-1:0] grant_oh,
  output logic               grant_valid,
  output logic               pkt_done
);

  localparam int PTR_W = $clog2(N_PORTS);
  localparam int CNT_W = $clog2(PKT_LEN + 1);

  localparam logic [IDX_W-1:0] C_IDX_IDLE = '1;
  localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(N_PORTS - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(PKT_LEN - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t             r_state, w_nxt_state;
  logic [PTR_W-1:0]   r_ptr, w_nxt_ptr;
  logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
  logic [IDX_W-1:0]   r_grant_idx, w_nxt_grant_idx;
  logic [N_PORTS-1:0] r_grant_oh, w_nxt_grant_oh;
  logic               r_grant_valid, w_nxt_grant_valid;
  logic               r_pkt_done, w_nxt_pkt_done;

  logic [N_PORTS-1:0] w_elig;
  logic               w_found;
  logic [IDX_W-1:0]   w_win_idx;
  logic [N_PORTS-1:0] w_win_oh;
  logic               w_release;
  logic [PTR_W-1:0]   w_ptr_inc;

  assign w_elig = req & ~mask;

  // The packet ends either on a tail flit or on the last counted flit.
  // Because TAIL_MODE is a parameter, synthesis folds away the unused branch.
  assign w_release = flit_valid &
                     ((TAIL_MODE != 0) ? flit_tail : (r_cnt == C_CNT_LAST));

  // After a packet, the port just past the granted one gets top priority.
  assign w_ptr_inc = (r_grant_idx == C_IDX_LAST) ? '0
                                                 : PTR_W'(r_grant_idx + C_IDX_ONE);

  // Rotating-priority pick. The first pass scans ports from ptr upward.
  // If that finds nothing, the second pass wraps around from port 0.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_win_oh  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (!w_found && w_elig[i] && (i >= int'(r_ptr))) begin
        w_found     = 1'b1;
        w_win_idx   = IDX_W'(i);
        w_win_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < N_PORTS; i++) begin
      if (!w_found && w_elig[i]) begin
        w_found     = 1'b1;
        w_win_idx   = IDX_W'(i);
        w_win_oh[i] = 1'b1;
      end
    end
  end

  // Next state and next registered outputs. The grant is frozen while locked.
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_ptr         = r_ptr;
    w_nxt_cnt         = r_cnt;
    w_nxt_grant_idx   = r_grant_idx;
    w_nxt_grant_oh    = r_grant_oh;
    w_nxt_grant_valid = r_grant_valid;
    w_nxt_pkt_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_nxt_state       = S_LOCKED;
          w_nxt_grant_idx   = w_win_idx;
          w_nxt_grant_oh    = w_win_oh;
          w_nxt_grant_valid = 1'b1;
          w_nxt_cnt         = '0;
        end
      end
      S_LOCKED: begin
        if (w_release) begin
          w_nxt_state       = S_IDLE;
          w_nxt_grant_idx   = C_IDX_IDLE;
          w_nxt_grant_oh    = '0;
          w_nxt_grant_valid = 1'b0;
          w_nxt_pkt_done    = 1'b1;
          w_nxt_ptr         = w_ptr_inc;
          w_nxt_cnt         = '0;
        end else if (flit_valid) begin
          // In tail mode the count is debug-only, so it saturates instead of wrapping.
          if (TAIL_MODE != 0) begin
            if (r_cnt != C_CNT_MAX) begin
              w_nxt_cnt = r_cnt + C_CNT_ONE;
            end
          end else begin
            w_nxt_cnt = r_cnt + C_CNT_ONE;
          end
        end
      end
      default: begin
        w_nxt_state       = S_IDLE;
        w_nxt_grant_idx   = C_IDX_IDLE;
        w_nxt_grant_oh    = '0;
        w_nxt_grant_valid = 1'b0;
        w_nxt_cnt         = '0;
      end
    endcase
  end

  // State and output registers. An asynchronous reset drops any lock at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_grant_idx   <= C_IDX_IDLE;
      r_grant_oh    <= '0;
      r_grant_valid <= 1'b0;
      r_pkt_done    <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_ptr         <= w_nxt_ptr;
      r_cnt         <= w_nxt_cnt;
      r_grant_idx   <= w_nxt_grant_idx;
      r_grant_oh    <= w_nxt_grant_oh;
      r_grant_valid <= w_nxt_grant_valid;
      r_pkt_done    <= w_nxt_pkt_done;
    end
  end

  assign grant_idx   = r_grant_idx;
  assign grant_oh    = r_grant_oh;
  assign grant_valid = r_grant_valid;
  assign pkt_done    = r_pkt_done;

endmodule
`default_nettype wire

// File: doc/noc_pkt_rr_arb.md
Name: noc_pkt_rr_arb

Overview:
- Parametrised output-port arbiter for the NoC router. Selects one of N_PORTS input ports with a round-robin pointer and per-port masking.
- Locks the grant for a whole packet. In fixed-length mode the packet is PKT_LEN valid flits; in tail mode it ends on a tail flit.
- Its own rotating-priority logic replaces the external DesignWare arbiter and the hard-wired five-port, five-flit lock.
- One instance per router output port. Drives the crossbar select.

Parameters:
- N_PORTS, 5, number of requesting input ports (2..16).
- PKT_LEN, 5, flits per packet in fixed-length mode (>=1).
- TAIL_MODE, 0, release rule: 0 = release after PKT_LEN valid flits; 1 = release on a valid flit with flit_tail=1, and PKT_LEN is ignored.
- IDX_W, $clog2(N_PORTS+1), width of grant_idx. The all-ones code is never a legal port index.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, reset: asynchronous, active-low.
- req, input, N_PORTS, per-port request; bit i = input port i.
- mask, input, N_PORTS, per-port mask; 1 = port i is not eligible.
- flit_valid, input, 1, one flit of the granted packet crosses the output this cycle.
- flit_tail, input, 1, the current flit is a tail; used only when TAIL_MODE=1.
- grant_idx, output, IDX_W, index of the granted port; all-ones when idle.
- grant_oh, output, N_PORTS, one-hot grant; zero when idle.
- grant_valid, output, 1, the grant is held (LOCKED state).
- pkt_done, output, 1, one-cycle pulse after a packet releases the grant.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, rr pointer=0 (port 0 has highest priority), flit count=0.
  - grant_idx=all-ones, grant_oh=0, grant_valid=0, pkt_done=0.
  - Reset asserted mid-packet aborts the lock immediately. No pkt_done is generated.
- All outputs are registered.
- eligible = req & ~mask.
- IDLE:
  - If eligible≠0, pick the first set bit scanning ptr, ptr+1, … mod N_PORTS.
  - Next cycle: state=LOCKED, grant_idx=winner, grant_oh bit set, grant_valid=1, count=0.
  - If eligible=0, stay IDLE with outputs at idle values.
  - Latency from request to grant is 1 cycle.
- LOCKED:
  - grant_idx and grant_oh are held. Changes in req or mask, including the granted port dropping req or becoming masked, are ignored until release.
  - Each cycle with flit_valid=1 increments count (width $clog2(PKT_LEN+1)). Cycles with flit_valid=0 stall the count with no limit.
  - TAIL_MODE=0: release on the cycle where flit_valid=1 and count==PKT_LEN-1. PKT_LEN=1 releases on the first valid flit.
  - TAIL_MODE=1: release on the cycle where flit_valid=1 and flit_tail=1. The count is kept only for debug and saturates at its maximum.
  - flit_tail is ignored when TAIL_MODE=0.
- Release cycle k:
  - At k+1: state=IDLE, grant_valid=0, grant_idx=all-ones, grant_oh=0, pkt_done=1 for one cycle, ptr=(granted+1) mod N_PORTS.
  - The IDLE cycle at k+1 arbitrates using the updated ptr. The next grant appears at k+2, so there is exactly one bubble cycle between packets.
- flit_valid seen in IDLE is ignored.
- Fairness: with all ports continuously eligible, each port is granted once every N_PORTS packets.

Test Plan:
- Fairness, default params: all 5 ports request, mask=0, flit_valid=1 constant.
  - grant_idx sequence 0,1,2,3,4,0.
  - Each grant_valid window lasts 5 cycles with a 1-cycle gap; pkt_done pulses on each gap cycle.
- Idle encoding:
  - req=0 → grant_idx=3'b111, grant_oh=0, grant_valid=0 for all cycles.
  - req=5'b00100 → grant_idx=2 one cycle later.
- Masking: req=5'b11111, mask=5'b01011 after reset.
  - Grants 2,4,2,4.
  - Setting mask bit 2 mid-packet does not drop the current grant.
- Flit stalls, PKT_LEN=3: port 1 granted, flit_valid pattern 1,0,0,1,0,1.
  - Grant is held until the third valid flit; release and pkt_done occur the next cycle.
- Tail mode, TAIL_MODE=1: port 3 sends valid flits with tail on the 7th flit.
  - Grant held for 7 valid flits regardless of PKT_LEN; ptr then gives port 4 priority.
- Async reset mid-packet: assert rst_n=0 between clock edges while port 0 is locked.
  - Outputs go to idle values immediately, without waiting for a clock edge; no pkt_done.
  - After release, all ports request: port 0 is granted first.
